// File: rtl/store_buffer_pkg.sv
// Shared types for the data-bus store buffer.
// Holds the dbus request/response payloads (reused unchanged from the core),
// the buffered store entry layout, drain FSM state encoding and default depth.
package store_buffer_pkg;

   localparam int unsigned SB_DEPTH = 4;
   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned STRB_W   = 4;
   localparam int unsigned SIZE_W   = 3;

   typedef logic [SIZE_W-1:0] msize_t;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      msize_t            size;
      logic [STRB_W-1:0] strobe;
      logic [DATA_W-1:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic              addr_ok;
      logic              data_ok;
      logic [DATA_W-1:0] data;
   } dbus_resp_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      msize_t            size;
      logic [STRB_W-1:0] strobe;
      logic [DATA_W-1:0] data;
   } sb_entry_t;

   typedef enum logic [2:0] {
      IDLE,
      S_REQ,
      S_WAIT,
      L_REQ,
      L_WAIT
   } sb_state_t;

   // Capture the store fields of a request into an entry.
   function automatic sb_entry_t req_to_entry(input dbus_req_t r);
      sb_entry_t e;
      e.addr   = r.addr;
      e.size   = r.size;
      e.strobe = r.strobe;
      e.data   = r.data;
      return e;
   endfunction

   // Turn a buffered entry back into a valid memory request.
   function automatic dbus_req_t entry_to_req(input sb_entry_t e);
      dbus_req_t r;
      r.valid  = 1'b1;
      r.addr   = e.addr;
      r.size   = e.size;
      r.strobe = e.strobe;
      r.data   = e.data;
      return r;
   endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Bus bundle around the store buffer.
//   creq  : MMU -> buffer request      cresp : buffer -> MMU response
//   dreq  : buffer -> memory request   dresp : memory -> buffer response
// Modport slave is the store buffer's view; master is the environment
// (MMU plus memory) driving it.
interface store_buffer_if;
   import store_buffer_pkg::*;

   dbus_req_t  creq;
   dbus_resp_t cresp;
   dbus_req_t  dreq;
   dbus_resp_t dresp;

   modport slave (
      input  creq,
      input  dresp,
      output cresp,
      output dreq
   );

   modport master (
      output creq,
      output dresp,
      input  cresp,
      input  dreq
   );

endinterface

// File: rtl/store_buffer_fifo.sv
// Store entry storage for the store buffer: circular queue with head/tail
// pointers, occupancy count and per-entry valid bits.
// Ports: clk, reset (sync, active-high), push/push_entry, pop, head_entry,
// count, full, empty. With SB_LOAD_BYPASS_EN defined it also exposes a word
// address probe (probe_waddr -> probe_hit_c) compared against every valid entry.
module sb_fifo
   import store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = SB_DEPTH,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  sb_entry_t        push_entry,
   input  logic             pop,
   output sb_entry_t        head_entry,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
`ifdef SB_LOAD_BYPASS_EN
   ,
   input  logic [ADDR_W-3:0] probe_waddr,
   output logic              probe_hit_c
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   sb_entry_t        mem_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [CNT_W-1:0] count_q;
   logic [DEPTH-1:0] push_mask;
   logic [DEPTH-1:0] pop_mask;

   // One-hot slot masks for the valid-bit update.
   always_comb begin
      push_mask         = '0;
      pop_mask          = '0;
      push_mask[tail_q] = push;
      pop_mask[head_q]  = pop;
   end

   // Pointers, count and valid bits; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + PTR_W'(1);
         if (pop)  head_q <= head_q + PTR_W'(1);
         valid_q <= (valid_q & ~pop_mask) | push_mask;
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload storage needs no reset; valid bits qualify it.
   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= push_entry;
   end

   assign head_entry = mem_q[head_q];
   assign count      = count_q;
   assign full       = (count_q == CNT_W'(DEPTH));
   assign empty      = (count_q == '0);

`ifdef SB_LOAD_BYPASS_EN
   // Word-address match of a load against every pending store.
   always_comb begin
      probe_hit_c = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (valid_q[PTR_W'(i)] && (mem_q[PTR_W'(i)].addr[ADDR_W-1:2] == probe_waddr))
            probe_hit_c = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the MMU execute unit and the core dbus.
// Stores are acknowledged as soon as they are buffered; a drain FSM writes
// them to memory in order and also issues loads, ordered against stores.
// Ports: clk, reset (sync, active-high), bus (store_buffer_if.slave carrying
// creq/cresp/dreq/dresp), sb_empty, sb_full, sb_count.
// Optional: SB_LOAD_BYPASS_EN lets loads overtake pending stores to other
// word addresses; undefined keeps strict program order.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter  int unsigned DEPTH = SB_DEPTH,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   store_buffer_if.slave    bus,
   output logic             sb_empty,
   output logic             sb_full,
   output logic [CNT_W-1:0] sb_count
);

   sb_state_t  state_q;
   dbus_req_t  dreq_q;
   dbus_resp_t cresp_c;
   sb_entry_t  head_entry;
   logic       fifo_empty;
   logic       is_store_c;
   logic       is_load_c;
   logic       push_c;
   logic       pop_c;
   logic       load_ok_c;

   assign is_store_c = bus.creq.valid && (bus.creq.strobe != '0);
   assign is_load_c  = bus.creq.valid && (bus.creq.strobe == '0);

   // Full is the registered count, so a same-cycle pop never frees a slot.
   assign push_c = is_store_c && !sb_full && !reset;
   assign pop_c  = ((state_q == S_REQ) && bus.dresp.addr_ok && bus.dresp.data_ok) ||
                   ((state_q == S_WAIT) && bus.dresp.data_ok);

`ifdef SB_LOAD_BYPASS_EN
   logic probe_hit_c;

   sb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (push_c),
      .push_entry  (req_to_entry(bus.creq)),
      .pop         (pop_c),
      .head_entry  (head_entry),
      .count       (sb_count),
      .full        (sb_full),
      .empty       (fifo_empty),
      .probe_waddr (bus.creq.addr[ADDR_W-1:2]),
      .probe_hit_c (probe_hit_c)
   );

   assign load_ok_c = (state_q == IDLE) && !probe_hit_c;
`else
   sb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push_c),
      .push_entry (req_to_entry(bus.creq)),
      .pop        (pop_c),
      .head_entry (head_entry),
      .count      (sb_count),
      .full       (sb_full),
      .empty      (fifo_empty)
   );

   assign load_ok_c = (state_q == IDLE) && fifo_empty;
`endif

   // MMU response: zero-latency store ack, load handshake forwarded from memory.
   always_comb begin
      cresp_c = '0;
      if (!reset) begin
         if (push_c) begin
            cresp_c.addr_ok = 1'b1;
            cresp_c.data_ok = 1'b1;
         end
         if ((state_q == L_REQ) && bus.dresp.addr_ok)
            cresp_c.addr_ok = 1'b1;
         if (((state_q == L_REQ) && bus.dresp.addr_ok && bus.dresp.data_ok) ||
             ((state_q == L_WAIT) && bus.dresp.data_ok)) begin
            cresp_c.data_ok = 1'b1;
            cresp_c.data    = bus.dresp.data;
         end
      end
   end

   // Drain FSM with registered memory request; dreq drops once addr_ok is seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         dreq_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (is_load_c && load_ok_c) begin
                  state_q <= L_REQ;
                  dreq_q  <= bus.creq;
               end else if (!fifo_empty) begin
                  state_q <= S_REQ;
                  dreq_q  <= entry_to_req(head_entry);
               end
            end
            S_REQ: begin
               if (bus.dresp.addr_ok) begin
                  dreq_q  <= '0;
                  state_q <= bus.dresp.data_ok ? IDLE : S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.dresp.data_ok) state_q <= IDLE;
            end
            L_REQ: begin
               if (bus.dresp.addr_ok) begin
                  dreq_q  <= '0;
                  state_q <= bus.dresp.data_ok ? IDLE : L_WAIT;
               end
            end
            L_WAIT: begin
               if (bus.dresp.data_ok) state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               dreq_q  <= '0;
            end
         endcase
      end
   end

   assign bus.dreq  = dreq_q;
   assign bus.cresp = cresp_c;
   assign sb_empty  = fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: bench-side MMU driver, memory model
// with stall / single-cycle / split response modes, and a store scoreboard
// checked as stores reach memory. Load results are checked against a
// reference memory updated in program order.
module tb_store_buffer;
   import store_buffer_pkg::*;

   localparam int unsigned CNT_W = $clog2(SB_DEPTH) + 1;

   typedef enum int {MEM_STALL, MEM_FAST, MEM_SPLIT} mem_mode_t;
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } st_exp_t;

   logic             clk;
   logic             reset;
   logic             sb_empty;
   logic             sb_full;
   logic [CNT_W-1:0] sb_count;

   store_buffer_if bus ();

   store_buffer #(.DEPTH(SB_DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .sb_empty (sb_empty),
      .sb_full  (sb_full),
      .sb_count (sb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errs   = 0;
   mem_mode_t   mem_mode = MEM_STALL;
   int          max_cnt  = 0;
   int          ld_pend  = -1;
   int          wait_cnt = 0;
   logic [31:0] rd_latched;
   st_exp_t     exp_st [$];
   logic [31:0] exp_ld [$];
   logic [31:0] mem     [logic [29:0]];
   logic [31:0] ref_mem [logic [29:0]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [29:0] w);
      return {2'b00, w} ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [29:0] w);
      return mem.exists(w) ? mem[w] : init_word(w);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [29:0] w);
      return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
   endfunction

   // Memory model: serves dreq, scoreboards stores, checks load ordering.
   always @(negedge clk) begin
      dbus_resp_t r;
      dbus_req_t  q;
      st_exp_t    e;
      logic       hit;
      r = '0;
      q = bus.dreq;
      if (int'(sb_count) > max_cnt) max_cnt = int'(sb_count);
      if (reset) begin
         wait_cnt = 0;
      end else if (wait_cnt != 0) begin
         check("split_no_new_req", 32'(q.valid), 32'd0);
         wait_cnt--;
         if (wait_cnt == 0) begin
            r.data_ok = 1'b1;
            r.data    = rd_latched;
         end
      end else if (q.valid && (mem_mode != MEM_STALL)) begin
         rd_latched = 32'h0;
         if (q.strobe != 4'h0) begin
            if (exp_st.size() == 0) begin
               check("st_unexpected", q.addr, 32'hFFFF_FFFF);
            end else begin
               e = exp_st.pop_front();
               check("st_order_addr", q.addr, e.addr);
               check("st_order_data", q.data, e.data);
            end
            mem[q.addr[31:2]] = merge(mem_rd(q.addr[31:2]), q.data, q.strobe);
         end else begin
            hit = 1'b0;
            foreach (exp_st[i])
               if (exp_st[i].addr[31:2] == q.addr[31:2]) hit = 1'b1;
            check("ld_vs_matching_store", 32'(hit), 32'd0);
`ifndef SB_LOAD_BYPASS_EN
            check("ld_strict_order", 32'(exp_st.size()), 32'd0);
`endif
            ld_pend    = exp_st.size();
            rd_latched = mem_rd(q.addr[31:2]);
         end
         r.addr_ok = 1'b1;
         if (mem_mode == MEM_FAST) begin
            r.data_ok = 1'b1;
            r.data    = rd_latched;
         end else begin
            wait_cnt = 3;
         end
      end
      bus.dresp = r;
   end

   // Drive a store at a negedge and wait (bounded) for the combinational ack.
   task automatic mmu_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int budget, output int waited);
      bus.creq = '{valid: 1'b1, addr: a, size: 3'd2, strobe: s, data: d};
      waited = 0;
      #1;
      while (!bus.cresp.addr_ok && waited < budget) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (bus.cresp.addr_ok) begin
         check("st_ack_data_ok", 32'(bus.cresp.data_ok), 32'd1);
         exp_st.push_back('{addr: a, data: d});
         ref_mem[a[31:2]] = merge(ref_rd(a[31:2]), d, s);
      end else begin
         check("st_ack_timeout", 32'(bus.cresp.addr_ok), 32'd1);
      end
      @(negedge clk);
   endtask

   // Drive a load and compare returned data against the reference memory.
   task automatic mmu_load(input string tag, input logic [31:0] a, input int budget);
      int          waited;
      logic [31:0] e;
      exp_ld.push_back(ref_rd(a[31:2]));
      bus.creq = '{valid: 1'b1, addr: a, size: 3'd2, strobe: 4'h0, data: 32'h0};
      waited = 0;
      #1;
      while (!bus.cresp.data_ok && waited < budget) begin
         @(negedge clk);
         #1;
         waited++;
      end
      e = exp_ld.pop_front();
      if (bus.cresp.data_ok) check(tag, bus.cresp.data, e);
      else                   check({tag, "_timeout"}, 32'(bus.cresp.data_ok), 32'd1);
      @(negedge clk);
      bus.creq = '0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n;
      n = 0;
      while (!(sb_empty && exp_st.size() == 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(sb_empty && (exp_st.size() == 0)), 32'd1);
   endtask

   initial begin
      int   w;
      logic stalled_ack;

      // Reset with a live store request: nothing may be acked or issued.
      reset    = 1'b1;
      bus.creq = '{valid: 1'b1, addr: 32'h80, size: 3'd2, strobe: 4'hF, data: 32'h1111};
      repeat (2) @(negedge clk);
      #1;
      check("rst_cresp_ok",   32'({bus.cresp.addr_ok, bus.cresp.data_ok}), 32'd0);
      check("rst_cresp_data", bus.cresp.data, 32'd0);
      check("rst_dreq_valid", 32'(bus.dreq.valid), 32'd0);
      check("rst_count",      32'(sb_count), 32'd0);
      check("rst_empty",      32'(sb_empty), 32'd1);
      check("rst_full",       32'(sb_full), 32'd0);
      @(negedge clk);
      reset    = 1'b0;
      bus.creq = '0;
      @(negedge clk);

      // Store burst to full against a stalled memory.
      mem_mode = MEM_STALL;
      for (int i = 0; i < 4; i++) begin
         mmu_store(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 10, w);
         check("burst_ack_cycle", 32'(w), 32'd0);
      end
      check("burst_full", 32'(sb_full), 32'd1);
      check("burst_count", 32'(sb_count), 32'(SB_DEPTH));
      bus.creq = '{valid: 1'b1, addr: 32'h110, size: 3'd2, strobe: 4'hF, data: 32'hA000_0004};
      stalled_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (bus.cresp.addr_ok) stalled_ack = 1'b1;
         @(negedge clk);
      end
      check("full_no_ack", 32'(stalled_ack), 32'd0);
      check("stall_dreq_valid", 32'(bus.dreq.valid), 32'd1);
      check("stall_dreq_head", bus.dreq.addr, 32'h100);
      mem_mode = MEM_FAST;
      mmu_store(32'h110, 32'hA000_0004, 4'hF, 20, w);
      bus.creq = '0;
      wait_drain("burst_drain", 60);

      // Pointer wrap: ten stores through a single-cycle memory.
      max_cnt = 0;
      for (int i = 0; i < 10; i++)
         mmu_store(32'h400 + 32'(4 * i), 32'(i), 4'hF, 20, w);
      bus.creq = '0;
      wait_drain("wrap_drain", 80);
      check("wrap_max_count", 32'(max_cnt <= int'(SB_DEPTH)), 32'd1);

`ifdef SB_LOAD_BYPASS_EN
      // Bypass: unrelated load overtakes, matching load waits for its store.
      ld_pend = -1;
      mmu_store(32'h200, 32'h0A0A_0A0A, 4'hF, 20, w);
      mmu_store(32'h204, 32'h0B0B_0B0B, 4'hF, 20, w);
      mmu_load("byp_ld_300", 32'h300, 40);
      check("byp_overtake", 32'(ld_pend > 0), 32'd1);
      mmu_load("byp_ld_204", 32'h204, 40);
      wait_drain("byp_drain", 40);
`else
      // Strict ordering: load goes out only after the older store completes.
      mmu_store(32'h200, 32'hDEAD_BEEF, 4'hF, 20, w);
      mmu_load("strict_ld_300", 32'h300, 40);
      mmu_load("strict_ld_200", 32'h200, 40);
      wait_drain("strict_drain", 40);
`endif

      // Partial-word store merges into the existing word.
      mmu_store(32'h208, 32'h0000_AB00, 4'b0010, 20, w);
      mmu_load("byte_merge_ld", 32'h208, 40);
      wait_drain("byte_drain", 40);

      // Split memory response: addr_ok now, data_ok three cycles later.
      mem_mode = MEM_SPLIT;
      mmu_store(32'h500, 32'h5555_AAAA, 4'hF, 20, w);
      mmu_store(32'h504, 32'h1234_5678, 4'hF, 20, w);
      bus.creq = '0;
      wait_drain("split_drain", 60);
      mmu_load("split_ld_500", 32'h500, 40);
      mmu_load("split_ld_504", 32'h504, 40);
      check("end_empty", 32'(sb_empty), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer on the data bus, between the MMU execute unit (CPU side) and the dbus port of MyCore (memory side).
- Stores are acknowledged to the MMU as soon as they are buffered, so MMU stalls (mem_halt) only for loads and a full buffer.
- A drain FSM writes buffered stores to memory in order. It also issues loads, with ordering against pending stores enforced.

Parameters:
- DEPTH, 4, number of store entries; power of 2, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- creq  in  dbus_req_t  request from the MMU; fields valid, addr, size, strobe, data.
  - strobe != 0 means a store.
  - strobe == 0 means a load.
- cresp  out  dbus_resp_t  response to the MMU; fields addr_ok, data_ok, data.
- dreq  out  dbus_req_t  request to memory.
- dresp  in  dbus_resp_t  response from memory.
- sb_empty  out  1  no valid entries and FSM in IDLE.
- sb_full  out  1  count == DEPTH.
- sb_count  out  CNT_W  occupancy.

Behaviour:
- Interface: one clock clk; reset is synchronous, active-high, named reset.
- Reset values:
  - All entries invalid; head = tail = 0; count = 0; FSM = IDLE.
  - dreq = '0, cresp = '0.
  - sb_empty = 1, sb_full = 0.
- Entry storage: {addr[31:0], size, strobe[3:0], data[31:0]}.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Store accept:
  - Condition: creq.valid && strobe != 0 && !sb_full (full evaluated from registered count).
  - Response: cresp.addr_ok = cresp.data_ok = 1 combinationally in the same cycle.
  - The entry is written at tail; tail++ and count++ next edge.
  - When full: no ack; the MMU holds the request.
  - A pop in the same cycle does not enable a push when full. Decided: no push-on-pop at full.
- Push and pop in the same cycle (not full): count unchanged, both pointers advance.
- Drain FSM states:
  - IDLE:
    - Load pending and permitted goes to L_REQ. Load has priority only when permitted (see ordering).
    - Otherwise count != 0 goes to S_REQ.
    - Otherwise stay.
  - S_REQ:
    - dreq driven from the head entry with valid = 1, held stable until dresp.addr_ok.
    - If addr_ok and data_ok arrive in the same cycle: pop and go to IDLE.
    - If addr_ok only: go to S_WAIT.
  - S_WAIT: on dresp.data_ok, pop head (head++, count--) and go to IDLE.
  - L_REQ:
    - dreq = creq (strobe = 0), valid = 1, until addr_ok.
    - If data_ok is also seen: finish as in L_WAIT.
  - L_WAIT:
    - On dresp.data_ok: cresp.data_ok = 1, cresp.data = dresp.data in that cycle, then go to IDLE.
    - cresp.addr_ok for a load is asserted in the cycle dresp.addr_ok is seen.
- Load ordering (base build): a load is permitted only when count == 0 and FSM is IDLE, i.e. strict program order.
- Latency:
  - Store ack: 0 cycles.
  - Store to memory: at least 1 cycle after push.
  - Load: at least 2 cycles with an empty buffer and a 1-cycle memory.
- Invalid combinations:
  - No new dreq is issued while an outstanding transaction is awaiting data_ok.
  - creq.valid == 0 produces no response.
- Reset mid-transaction: state is discarded and dreq.valid drops next cycle. Buffered stores are lost, as is architecturally intended on reset.
- No flush input. An accepted store is committed and always drains.

Optional Feature:
- Macro: SB_LOAD_BYPASS_EN.
- When defined:
  - A load is permitted while stores are pending if no valid entry has a matching word address (addr[31:2]).
  - The comparison is against all DEPTH entries, combinational.
  - On a match, the load waits until the matching entries drain.
  - In IDLE with both a permitted load and pending stores, the load wins.
- When undefined: strict ordering as above, and no comparators are synthesized.

Decomposition:
- Shared package / common.svh gains:
  - sb_entry_t struct.
  - sb_state_t enum {IDLE, S_REQ, S_WAIT, L_REQ, L_WAIT}.
  - SB_DEPTH constant.
- dbus_req_t / dbus_resp_t are reused unchanged.
- One natural sub-module: sb_fifo (storage, head/tail/count, full/empty). The FSM and arbitration stay in store_buffer.

Test Plan:
- Reset:
  - Stimulus: assert reset for 2 cycles with creq.valid = 1.
  - Required: sb_count = 0, sb_empty = 1, dreq.valid = 0, cresp = 0.
- Store burst to full:
  - Stimulus: 5 back-to-back stores to 0x100, 0x104, 0x108, 0x10C, 0x110; memory addr_ok held 0.
  - Required: first 4 acked in cycles 0-3; sb_full = 1; 5th unacked until the first pop.
  - Required: dreq.addr sequence 0x100, 0x104, … in order.
- Pointer wrap:
  - Stimulus: 10 stores (data i) with 1-cycle memory.
  - Required: memory receives data 0..9 in order; sb_count never exceeds 4.
- Strict ordering (macro off):
  - Stimulus: store 0xDEADBEEF to 0x200, then load 0x300.
  - Required: load dreq appears only after the store's data_ok; cresp.data = memory value.
- Bypass (macro on):
  - Stimulus: 2 stores pending to 0x200/0x204; load 0x300.
  - Required: load issued before the stores.
  - Stimulus: load 0x204.
  - Required: waits until count = 0; returns 0x204's stored value.
- Split response:
  - Stimulus: memory gives addr_ok, then data_ok 3 cycles later.
  - Required: FSM sits in S_WAIT; no new dreq.valid until pop.
